// File: rtl/stk_pipe_ad_iss_sched_if.sv
// Issue-scheduler bus for the stk AD stage: engine requests, invalidation
// request, active-bit strobes and the registered issue slot.
interface stk_pipe_ad_iss_sched_if #(
    parameter int ENGS_N  = 4,
    parameter int ENGID_W = $clog2(ENGS_N)
);
    logic [ENGS_N-1:0]  i_eng_req;
    logic [ENGS_N-1:0]  o_eng_ack;
    logic               i_inv_req;
    logic [ENGID_W-1:0] i_inv_engid;
    logic               o_inv_ack;
    logic [ENGS_N-1:0]  i_active_set_d;
    logic [ENGS_N-1:0]  i_active_clr_d;
    logic               i_stall;
    logic               o_iss_vld_r;
    logic [ENGID_W-1:0] o_iss_engid_r;
    logic               o_iss_inv_r;
    logic [ENGS_N-1:0]  o_active_r;

    modport master (
        output i_eng_req, i_inv_req, i_inv_engid,
        output i_active_set_d, i_active_clr_d, i_stall,
        input  o_eng_ack, o_inv_ack,
        input  o_iss_vld_r, o_iss_engid_r, o_iss_inv_r, o_active_r
    );

    modport slave (
        input  i_eng_req, i_inv_req, i_inv_engid,
        input  i_active_set_d, i_active_clr_d, i_stall,
        output o_eng_ack, o_inv_ack,
        output o_iss_vld_r, o_iss_engid_r, o_iss_inv_r, o_active_r
    );
endinterface

// File: rtl/stk_pipe_ad_iss_sched.sv
// AD-stage issue scheduler: shares one issue slot between round-robin
// engine requesters and the invalidation controller.
module stk_pipe_ad_iss_sched #(
    parameter int ENGS_N  = 4,
    parameter int ENGID_W = $clog2(ENGS_N),
    parameter int INV_MAX = 4
) (
    input logic                    clk,
    input logic                    arst_n,
    stk_pipe_ad_iss_sched_if.slave bus
);
    localparam int CNT_W = $clog2(INV_MAX + 1);

    logic [ENGS_N-1:0]  active_q, active_d;
    logic [ENGID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic               iss_vld_q, iss_vld_d;
    logic [ENGID_W-1:0] iss_engid_q, iss_engid_d;
    logic               iss_inv_q, iss_inv_d;

    logic [ENGS_N-1:0]  elig;
    logic               eng_hit;
    logic [ENGID_W-1:0] eng_id;
    logic [ENGID_W-1:0] idx;
    logic               inv_win;
    logic               eng_win;

    assign active_d = (active_q | bus.i_active_set_d) & ~bus.i_active_clr_d;
    assign elig     = bus.i_eng_req & ~active_q;

    // Scan from the pointer upward; id width wraps the index modulo ENGS_N.
    always_comb begin
        eng_hit = 1'b0;
        eng_id  = '0;
        idx     = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            idx = rr_ptr_q + ENGID_W'(i);
            if (!eng_hit && elig[idx]) begin
                eng_hit = 1'b1;
                eng_id  = idx;
            end
        end
    end

    assign inv_win = !bus.i_stall && bus.i_inv_req &&
                     ((inv_cnt_q < CNT_W'(INV_MAX)) || (elig == '0));
    assign eng_win = !bus.i_stall && !inv_win && eng_hit;

    assign bus.o_inv_ack = inv_win;
    assign bus.o_eng_ack = eng_win ? (ENGS_N'(1) << eng_id) : '0;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        inv_cnt_d   = inv_cnt_q;
        iss_vld_d   = 1'b0;
        iss_engid_d = iss_engid_q;
        iss_inv_d   = iss_inv_q;
        if (inv_win) begin
            if (inv_cnt_q < CNT_W'(INV_MAX)) begin
                inv_cnt_d = inv_cnt_q + CNT_W'(1);
            end
            iss_vld_d   = 1'b1;
            iss_inv_d   = 1'b1;
            iss_engid_d = bus.i_inv_engid;
        end else if (eng_win) begin
            rr_ptr_d    = eng_id + ENGID_W'(1);
            inv_cnt_d   = '0;
            iss_vld_d   = 1'b1;
            iss_inv_d   = 1'b0;
            iss_engid_d = eng_id;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            active_q    <= '0;
            rr_ptr_q    <= '0;
            inv_cnt_q   <= '0;
            iss_vld_q   <= 1'b0;
            iss_engid_q <= '0;
            iss_inv_q   <= 1'b0;
        end else begin
            active_q    <= active_d;
            rr_ptr_q    <= rr_ptr_d;
            inv_cnt_q   <= inv_cnt_d;
            iss_vld_q   <= iss_vld_d;
            iss_engid_q <= iss_engid_d;
            iss_inv_q   <= iss_inv_d;
        end
    end

    assign bus.o_active_r    = active_q;
    assign bus.o_iss_vld_r   = iss_vld_q;
    assign bus.o_iss_engid_r = iss_engid_q;
    assign bus.o_iss_inv_r   = iss_inv_q;
endmodule

// File: tb/tb_stk_pipe_ad_iss_sched.sv
// Directed bench for the AD-stage issue scheduler.
module tb_stk_pipe_ad_iss_sched;
    logic clk;
    logic arst_n;
    int   n_assert;
    int   n_fail;

    stk_pipe_ad_iss_sched_if #(.ENGS_N(4)) bus ();

    stk_pipe_ad_iss_sched #(.ENGS_N(4), .INV_MAX(4)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic inv,
                         input logic [1:0] iid, input logic [3:0] set,
                         input logic [3:0] clr, input logic stall);
        bus.i_eng_req      = req;
        bus.i_inv_req      = inv;
        bus.i_inv_engid    = iid;
        bus.i_active_set_d = set;
        bus.i_active_clr_d = clr;
        bus.i_stall        = stall;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        #12;
        n_assert++;
        if (bus.o_iss_vld_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld got=%b exp=0", bus.o_iss_vld_r);
        end
        n_assert++;
        if (bus.o_iss_engid_r !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_engid got=%0d exp=0", bus.o_iss_engid_r);
        end
        n_assert++;
        if (bus.o_iss_inv_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_inv got=%b exp=0", bus.o_iss_inv_r);
        end
        n_assert++;
        if (bus.o_active_r !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_active got=%b exp=0000", bus.o_active_r);
        end
        tick();
        arst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
            exp_ack = 4'b0001 << k;
            @(negedge clk);
            n_assert++;
            if (bus.o_eng_ack !== exp_ack) begin
                n_fail++;
                $display("FAIL rr_ack[%0d] got=%b exp=%b", k, bus.o_eng_ack, exp_ack);
            end
            tick();
            n_assert++;
            if (bus.o_iss_vld_r !== 1'b1 || bus.o_iss_engid_r !== 2'(k) ||
                bus.o_iss_inv_r !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_issue[%0d] got=%b/%0d/%b exp=1/%0d/0", k,
                         bus.o_iss_vld_r, bus.o_iss_engid_r, bus.o_iss_inv_r, k);
            end
        end
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        tick();
        n_assert++;
        if (bus.o_iss_vld_r !== 1'b0 || bus.o_iss_engid_r !== 2'd3) begin
            n_fail++;
            $display("FAIL rr_idle got=%b/%0d exp=0/3",
                     bus.o_iss_vld_r, bus.o_iss_engid_r);
        end
    endtask

    task automatic test_active_mask();
        drive(4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0);
        tick();
        n_assert++;
        if (bus.o_active_r !== 4'b0100) begin
            n_fail++;
            $display("FAIL mask_set got=%b exp=0100", bus.o_active_r);
        end
        for (int t = 1; t <= 5; t++) begin
            drive(4'b0100, 1'b0, 2'd0, 4'b0000, (t == 5) ? 4'b0100 : 4'b0000, 1'b0);
            @(negedge clk);
            n_assert++;
            if (bus.o_eng_ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL mask_blocked[T+%0d] got=%b exp=0000", t, bus.o_eng_ack);
            end
            tick();
        end
        drive(4'b0100, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        n_assert++;
        if (bus.o_eng_ack !== 4'b0100 || bus.o_active_r !== 4'b0000) begin
            n_fail++;
            $display("FAIL mask_release got=%b/%b exp=0100/0000",
                     bus.o_eng_ack, bus.o_active_r);
        end
        tick();
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        n_assert++;
        if (bus.o_iss_engid_r !== 2'd2) begin
            n_fail++;
            $display("FAIL mask_issue got=%0d exp=2", bus.o_iss_engid_r);
        end
    endtask

    task automatic test_inv_starve();
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);
            @(negedge clk);
            n_assert++;
            if (bus.o_inv_ack !== 1'b1 || bus.o_eng_ack !== 4'b0000) begin
                n_fail++;
                $display("FAIL inv_grant[%0d] got=%b/%b exp=1/0000", k,
                         bus.o_inv_ack, bus.o_eng_ack);
            end
            tick();
            n_assert++;
            if (bus.o_iss_inv_r !== 1'b1 || bus.o_iss_engid_r !== 2'd2 ||
                bus.o_iss_vld_r !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_issue[%0d] got=%b/%0d/%b exp=1/2/1", k,
                         bus.o_iss_inv_r, bus.o_iss_engid_r, bus.o_iss_vld_r);
            end
        end
        @(negedge clk);
        n_assert++;
        if (bus.o_inv_ack !== 1'b0 || bus.o_eng_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL inv_forced_eng got=%b/%b exp=0/0001",
                     bus.o_inv_ack, bus.o_eng_ack);
        end
        tick();
        drive(4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);
        n_assert++;
        if (bus.o_iss_inv_r !== 1'b0 || bus.o_iss_engid_r !== 2'd0) begin
            n_fail++;
            $display("FAIL inv_forced_issue got=%b/%0d exp=0/0",
                     bus.o_iss_inv_r, bus.o_iss_engid_r);
        end
        @(negedge clk);
        n_assert++;
        if (bus.o_inv_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_resume got=%b exp=1", bus.o_inv_ack);
        end
        tick();
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    endtask

    task automatic test_set_clr_same();
        drive(4'b0000, 1'b0, 2'd0, 4'b1000, 4'b0000, 1'b0);
        tick();
        n_assert++;
        if (bus.o_active_r !== 4'b1000) begin
            n_fail++;
            $display("FAIL setclr_pre got=%b exp=1000", bus.o_active_r);
        end
        drive(4'b0000, 1'b0, 2'd0, 4'b1000, 4'b1000, 1'b0);
        tick();
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        n_assert++;
        if (bus.o_active_r !== 4'b0000) begin
            n_fail++;
            $display("FAIL setclr_same got=%b exp=0000", bus.o_active_r);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1);
            @(negedge clk);
            n_assert++;
            if (bus.o_eng_ack !== 4'b0000 || bus.o_inv_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ack[%0d] got=%b/%b exp=0000/0", k,
                         bus.o_eng_ack, bus.o_inv_ack);
            end
            tick();
            n_assert++;
            if (bus.o_iss_vld_r !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_vld[%0d] got=%b exp=0", k, bus.o_iss_vld_r);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
            @(negedge clk);
            n_assert++;
            if (bus.o_inv_ack !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_cnt_inv[%0d] got=%b exp=1", k, bus.o_inv_ack);
            end
            tick();
        end
        @(negedge clk);
        n_assert++;
        if (bus.o_inv_ack !== 1'b0 || bus.o_eng_ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_ptr got=%b/%b exp=0/0010",
                     bus.o_inv_ack, bus.o_eng_ack);
        end
        tick();
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        n_assert++;
        if (bus.o_iss_engid_r !== 2'd1 || bus.o_iss_inv_r !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_issue got=%0d/%b exp=1/0",
                     bus.o_iss_engid_r, bus.o_iss_inv_r);
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b0100, 1'b0, 2'd0, 4'b0010, 4'b0000, 1'b0);
        @(negedge clk);
        n_assert++;
        if (bus.o_eng_ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_mid_pre_ack got=%b exp=0100", bus.o_eng_ack);
        end
        tick();
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        n_assert++;
        if (bus.o_iss_vld_r !== 1'b1 || bus.o_iss_engid_r !== 2'd2 ||
            bus.o_active_r !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_mid_pre got=%b/%0d/%b exp=1/2/0010",
                     bus.o_iss_vld_r, bus.o_iss_engid_r, bus.o_active_r);
        end
        arst_n = 1'b0;
        #1;
        n_assert++;
        if (bus.o_iss_vld_r !== 1'b0 || bus.o_iss_engid_r !== 2'd0 ||
            bus.o_iss_inv_r !== 1'b0 || bus.o_active_r !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_clear got=%b/%0d/%b/%b exp=0/0/0/0000",
                     bus.o_iss_vld_r, bus.o_iss_engid_r, bus.o_iss_inv_r,
                     bus.o_active_r);
        end
        tick();
        arst_n = 1'b1;
        drive(4'b1111, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        n_assert++;
        if (bus.o_eng_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_first got=%b exp=0001", bus.o_eng_ack);
        end
        tick();
        drive(4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        n_assert++;
        if (bus.o_iss_vld_r !== 1'b1 || bus.o_iss_engid_r !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_issue got=%b/%0d exp=1/0",
                     bus.o_iss_vld_r, bus.o_iss_engid_r);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_round_robin();
        test_active_mask();
        test_inv_starve();
        test_set_clr_same();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
